panel_loader: RTL and testbench

PANEL_LOADER -- requirements
Module: panel_loader

---
 rtl/panel_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_panel_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_loader.sv
// rtl/panel_loader.sv - front-panel loader: deposits an image word by word, loads PC and runs the CPU
//
// Drives a PDP-8 style front panel (switches, load-PC and deposit buttons) from
// a stream of (address, data, last) image words. Each button operation is a
// SETUP / PRESS / REL triple, every phase HOLD_CYCLES clocks long. A shadow PC
// mirrors the CPU's deposit auto-increment so load-PC is only pressed when the
// next word is not at the address the CPU already points to. After the last
// word the loader loads START_PC, raises the run switch and waits for the CPU
// to halt.
//
// Optional feature: define PANEL_LOADER_COUNT_EN to add the deposit_count output.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    one-cycle pulse, begins a session from IDLE or HALTED
//   word_valid/word_ready    image word handshake; word_addr, word_data, word_last payload
//   sw[12:0]                 panel switches: [11:0] operand, [12] run
//   load_pc_btn, deposit_btn panel buttons
//   run_led                  CPU running indicator
//   busy, halted             status
//   deposit_count            (PANEL_LOADER_COUNT_EN only) deposits this session, saturating at 4096

module panel_loader #(
    parameter int          HOLD_CYCLES = 10,
    parameter logic [11:0] START_PC    = 12'o0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        word_valid,
    input  logic [11:0] word_addr,
    input  logic [11:0] word_data,
    input  logic        word_last,
    output logic        word_ready,
    output logic [12:0] sw,
    output logic        load_pc_btn,
    output logic        deposit_btn,
    input  logic        run_led,
    output logic        busy,
`ifdef PANEL_LOADER_COUNT_EN
    output logic        halted,
    output logic [12:0] deposit_count
`else
    output logic        halted
`endif
);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_WORD,
        LPC_SETUP,
        LPC_PRESS,
        LPC_REL,
        DEP_SETUP,
        DEP_PRESS,
        DEP_REL,
        GO_SETUP,
        RUN,
        HALTED
    } state_t;

    // Counter runs HOLD_CYCLES-1 .. 0, so a phase lasts HOLD_CYCLES clocks.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] operand_q, operand_d;
    logic        run_q, run_d;
    logic [11:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic [11:0] addr_q, addr_d;
    logic [11:0] data_q, data_d;
    logic        last_q, last_d;
    logic        go_q, go_d;       // current load-PC is the final START_PC load
    logic        run_led_q;
    logic        phase_done;
    logic        dep_done;

    assign phase_done = (cnt_q == 8'd0);
    assign dep_done   = (state_q == DEP_REL) && phase_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            operand_q  <= 12'd0;
            run_q      <= 1'b0;
            pc_q       <= 12'd0;
            pc_valid_q <= 1'b0;
            addr_q     <= 12'd0;
            data_q     <= 12'd0;
            last_q     <= 1'b0;
            go_q       <= 1'b0;
            run_led_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            operand_q  <= operand_d;
            run_q      <= run_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            last_q     <= last_d;
            go_q       <= go_d;
            run_led_q  <= run_led;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        operand_d  = operand_q;
        run_d      = run_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        last_d     = last_q;
        go_d       = go_q;

        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d    = WAIT_WORD;
                    pc_valid_d = 1'b0;
                    go_d       = 1'b0;
                    run_d      = 1'b0;
                    cnt_d      = 8'd0;
                end
            end
            WAIT_WORD: begin
                if (word_valid) begin
                    addr_d = word_addr;
                    data_d = word_data;
                    last_d = word_last;
                    cnt_d  = HOLD_LOAD;
                    if (!pc_valid_q || (pc_q != word_addr)) begin
                        state_d   = LPC_SETUP;
                        operand_d = word_addr;
                    end else begin
                        state_d   = DEP_SETUP;
                        operand_d = word_data;
                    end
                end
            end
            LPC_SETUP, LPC_PRESS, DEP_SETUP, DEP_PRESS, GO_SETUP: begin
                if (phase_done) begin
                    cnt_d = HOLD_LOAD;
                    case (state_q)
                        LPC_SETUP: state_d = LPC_PRESS;
                        LPC_PRESS: state_d = LPC_REL;
                        DEP_SETUP: state_d = DEP_PRESS;
                        DEP_PRESS: state_d = DEP_REL;
                        default:   state_d = LPC_PRESS;   // GO_SETUP is the setup of the START_PC load
                    endcase
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            LPC_REL: begin
                if (phase_done) begin
                    if (go_q) begin
                        state_d = RUN;
                        run_d   = 1'b1;
                        go_d    = 1'b0;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d    = DEP_SETUP;
                        operand_d  = data_q;
                        pc_d       = addr_q;
                        pc_valid_d = 1'b1;
                        cnt_d      = HOLD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DEP_REL: begin
                if (phase_done) begin
                    pc_d = pc_q + 12'd1;          // CPU auto-increments after deposit
                    if (last_q) begin
                        state_d   = GO_SETUP;
                        operand_d = START_PC;
                        go_d      = 1'b1;
                        cnt_d     = HOLD_LOAD;
                    end else begin
                        state_d = WAIT_WORD;
                        cnt_d   = 8'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RUN: begin
                if (run_led_q && !run_led) begin
                    state_d = HALTED;
                    run_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef PANEL_LOADER_COUNT_EN
    logic [12:0] dep_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dep_cnt_q <= 13'd0;
        end else if (start && ((state_q == IDLE) || (state_q == HALTED))) begin
            dep_cnt_q <= 13'd0;
        end else if (dep_done && (dep_cnt_q != 13'd4096)) begin
            dep_cnt_q <= dep_cnt_q + 13'd1;
        end
    end

    assign deposit_count = dep_cnt_q;
`else
    logic unused_dep_done;
    assign unused_dep_done = dep_done;
`endif

    // Buttons decode straight from the state register: an async reset moves the
    // state to IDLE and drops the button in the same instant.
    assign sw          = {run_q, operand_q};
    assign load_pc_btn = (state_q == LPC_PRESS);
    assign deposit_btn = (state_q == DEP_PRESS);
    assign word_ready  = (state_q == WAIT_WORD);
    assign busy        = (state_q != IDLE) && (state_q != HALTED);
    assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_panel_loader.sv
// tb/tb_panel_loader.sv - directed self-checking bench for panel_loader
module tb_panel_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        word_valid = 1'b0;
    logic [11:0] word_addr = 12'd0;
    logic [11:0] word_data = 12'd0;
    logic        word_last = 1'b0;
    logic        word_ready;
    logic [12:0] sw;
    logic        load_pc_btn;
    logic        deposit_btn;
    logic        run_led = 1'b0;
    logic        busy;
    logic        halted;
`ifdef PANEL_LOADER_COUNT_EN
    logic [12:0] deposit_count;
`endif

    int checks = 0;
    int errors = 0;

    panel_loader #(.HOLD_CYCLES(10), .START_PC(12'o0200)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .word_valid   (word_valid),
        .word_addr    (word_addr),
        .word_data    (word_data),
        .word_last    (word_last),
        .word_ready   (word_ready),
        .sw           (sw),
        .load_pc_btn  (load_pc_btn),
        .deposit_btn  (deposit_btn),
        .run_led      (run_led),
        .busy         (busy),
`ifdef PANEL_LOADER_COUNT_EN
        .halted       (halted),
        .deposit_count(deposit_count)
`else
        .halted       (halted)
`endif
    );

    always #5 clk = ~clk;

    // Button activity log, sampled on the falling edge.
    logic [11:0] lpc_log[$];
    logic [11:0] dep_log[$];
    logic        lpc_prev = 1'b0;
    logic        dep_prev = 1'b0;
    logic [11:0] held_sw = 12'd0;
    logic        sw_glitch = 1'b0;
    int          lpc_w = 0;
    int          dep_w = 0;
    int          last_lpc_w = 0;
    int          last_dep_w = 0;

    always @(negedge clk) begin
        if (load_pc_btn && !lpc_prev) begin
            lpc_log.push_back(sw[11:0]);
            held_sw = sw[11:0];
        end
        if (deposit_btn && !dep_prev) begin
            dep_log.push_back(sw[11:0]);
            held_sw = sw[11:0];
        end
        if ((load_pc_btn || deposit_btn) && ((sw[11:0] !== held_sw) || sw[12]))
            sw_glitch = 1'b1;
        if (load_pc_btn) lpc_w++;
        else if (lpc_prev) begin last_lpc_w = lpc_w; lpc_w = 0; end
        if (deposit_btn) dep_w++;
        else if (dep_prev) begin last_dep_w = dep_w; dep_w = 0; end
        lpc_prev = load_pc_btn;
        dep_prev = deposit_btn;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        lpc_log.delete();
        dep_log.delete();
        sw_glitch  = 1'b0;
        lpc_w      = 0;
        dep_w      = 0;
        last_lpc_w = 0;
        last_dep_w = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send(input logic [11:0] a, input logic [11:0] d, input logic l);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (word_ready) break;
        end
        check("word_ready reached", {31'd0, word_ready}, 32'd1);
        word_valid = 1'b1;
        word_addr  = a;
        word_data  = d;
        word_last  = l;
        @(negedge clk);
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sw[12]) break;
        end
        check({tag, " run reached"}, {31'd0, sw[12]}, 32'd1);
    endtask

    task automatic halt_cpu(input string tag);
        @(negedge clk) run_led = 1'b1;
        @(negedge clk) run_led = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, " halt sw12"}, {31'd0, sw[12]}, 32'd0);
        check({tag, " halted"}, {31'd0, halted}, 32'd1);
        check({tag, " busy after halt"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check("reset sw", {19'd0, sw}, 32'd0);
        check("reset lpc btn", {31'd0, load_pc_btn}, 32'd0);
        check("reset dep btn", {31'd0, deposit_btn}, 32'd0);
        check("reset ready", {31'd0, word_ready}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset halted", {31'd0, halted}, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Session 1: start coincides with a valid word; one word at 0
        clear_logs();
        @(negedge clk);
        start = 1'b1; word_valid = 1'b1; word_addr = 12'o0000; word_data = 12'o7402; word_last = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s1 word held in wait", {31'd0, word_ready}, 32'd1);
        check("s1 busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        word_valid = 1'b0; word_last = 1'b0;
        check("s1 accepted", {31'd0, word_ready}, 32'd0);
        check("s1 setup buttons low", {30'd0, load_pc_btn, deposit_btn}, 32'd0);
        wait_run("s1");
        check("s1 lpc count", lpc_log.size(), 2);
        check("s1 lpc0", {20'd0, lpc_log[0]}, 32'o0000);
        check("s1 lpc1", {20'd0, lpc_log[1]}, 32'o0200);
        check("s1 dep count", dep_log.size(), 1);
        check("s1 dep0", {20'd0, dep_log[0]}, 32'o7402);
        check("s1 dep width", last_dep_w, 10);
        check("s1 lpc width", last_lpc_w, 10);
        check("s1 sw stable", {31'd0, sw_glitch}, 32'd0);
        check("s1 run sw", {19'd0, sw}, 32'o10200);
        pulse_start();
        @(negedge clk);
        check("s1 start ignored in run", {30'd0, sw[12], word_ready}, 32'd2);
        halt_cpu("s1");

        // Session 2: 0,1,2 contiguous then 5
        clear_logs();
        pulse_start();
        check("s2 busy after start", {31'd0, busy}, 32'd1);
        send(12'o0000, 12'o0001, 1'b0);
        send(12'o0001, 12'o0002, 1'b0);
        send(12'o0002, 12'o0003, 1'b0);
        send(12'o0005, 12'o0004, 1'b1);
        wait_run("s2");
        check("s2 lpc count", lpc_log.size(), 3);
        check("s2 lpc0", {20'd0, lpc_log[0]}, 32'o0000);
        check("s2 lpc1", {20'd0, lpc_log[1]}, 32'o0005);
        check("s2 lpc2", {20'd0, lpc_log[2]}, 32'o0200);
        check("s2 dep count", dep_log.size(), 4);
        check("s2 dep3", {20'd0, dep_log[3]}, 32'o0004);
        check("s2 sw stable", {31'd0, sw_glitch}, 32'd0);
        halt_cpu("s2");

        // Session 3: shadow wraps 7777 -> 0
        clear_logs();
        pulse_start();
        send(12'o7777, 12'o1111, 1'b0);
        send(12'o0000, 12'o2222, 1'b0);
        send(12'o0001, 12'o3333, 1'b1);
        wait_run("s3");
        check("s3 lpc count", lpc_log.size(), 2);
        check("s3 lpc0", {20'd0, lpc_log[0]}, 32'o7777);
        check("s3 lpc1", {20'd0, lpc_log[1]}, 32'o0200);
        check("s3 dep count", dep_log.size(), 3);
        check("s3 dep1", {20'd0, dep_log[1]}, 32'o2222);
`ifdef PANEL_LOADER_COUNT_EN
        check("s3 deposit_count", {19'd0, deposit_count}, 32'd3);
`endif
        halt_cpu("s3");

        // Session 4: reset during DEP_PRESS, then a clean session
        clear_logs();
        pulse_start();
        send(12'o0003, 12'o4444, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (deposit_btn) break;
        end
        check("s4 dep press reached", {31'd0, deposit_btn}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("s4 rst dep btn", {31'd0, deposit_btn}, 32'd0);
        check("s4 rst busy", {31'd0, busy}, 32'd0);
        check("s4 rst sw", {19'd0, sw}, 32'd0);
        check("s4 rst ready", {31'd0, word_ready}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("s4 no glitch after rst", {29'd0, deposit_btn, busy, halted}, 32'd0);
        clear_logs();
        pulse_start();
        send(12'o0003, 12'o4444, 1'b1);
        wait_run("s4");
        check("s4 lpc count", lpc_log.size(), 2);
        check("s4 lpc0", {20'd0, lpc_log[0]}, 32'o0003);
        check("s4 dep0", {20'd0, dep_log[0]}, 32'o4444);
        check("s4 dep width", last_dep_w, 10);
`ifdef PANEL_LOADER_COUNT_EN
        check("s4 deposit_count", {19'd0, deposit_count}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
